// File: rtl/pic_pkg.sv
// pic_pkg: shared register map, command opcodes, control bits, FSM states and priority helpers
package pic_pkg;
  localparam logic [1:0] ADDR_CTRL  = 2'd0;
  localparam logic [1:0] ADDR_VBASE = 2'd1;
  localparam logic [1:0] ADDR_IMR   = 2'd2;
  localparam logic [1:0] ADDR_CMD   = 2'd3;
  localparam logic [1:0] CMD_NSEOI  = 2'b01;
  localparam logic [1:0] CMD_SEOI   = 2'b10;
  localparam logic [1:0] CMD_SETPRI = 2'b11;
  localparam int CTRL_LTIM = 0;
  localparam int CTRL_AEOI = 1;
  localparam int CTRL_ROT  = 2;
  typedef enum logic {IDLE, ACK1} state_t;
  function automatic int prio_base(input logic rot, input int last_id, input int n);
    return rot ? (last_id + 1) % n : 0;
  endfunction
  function automatic int prio_rank(input int id, input int base, input int n);
    return (id - base + n) % n;
  endfunction
endpackage

// File: rtl/pic_prio_resolver.sv
// pic_prio_resolver: highest-priority set bit of req and of isr under nested or rotating order
module pic_prio_resolver
  import pic_pkg::*;
#(
  parameter int N_IRQ = 8,
  parameter int ID_W  = $clog2(N_IRQ)
) (
  input  logic [N_IRQ-1:0] req,
  input  logic [N_IRQ-1:0] isr,
  input  logic             rot,
  input  logic [ID_W-1:0]  last_id,
  output logic             found,
  output logic [ID_W-1:0]  id,
  output logic             isr_any,
  output logic [ID_W-1:0]  isr_top_id
);
  int base;
  logic [ID_W-1:0] ord [N_IRQ];
  assign base = prio_base(rot, int'(last_id), N_IRQ);
  for (genvar g = 0; g < N_IRQ; g++) begin : g_ord
    assign ord[g] = ID_W'((base + g) % N_IRQ);
  end
  always_comb begin
    found = 1'b0;
    id = '0;
    isr_any = 1'b0;
    isr_top_id = '0;
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      if (req[ord[k]]) begin
        found = 1'b1;
        id = ord[k];
      end
      if (isr[ord[k]]) begin
        isr_any = 1'b1;
        isr_top_id = ord[k];
      end
    end
  end
endmodule

// File: rtl/pic_sync_core.sv
// pic_sync_core: clocked 8259-style interrupt controller with nested/rotating priority and two-pulse ack
module pic_sync_core
  import pic_pkg::*;
#(
  parameter  int N_IRQ = 8,
  parameter  int VEC_W = 8,
  localparam int ID_W  = $clog2(N_IRQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq,
  input  logic             wr_en,
  input  logic [1:0]       wr_addr,
  input  logic [VEC_W-1:0] wr_data,
  input  logic             inta,
  output logic             intr,
  output logic [VEC_W-1:0] vector,
  output logic             vector_valid,
  output logic [N_IRQ-1:0] irr_o,
  output logic [N_IRQ-1:0] isr_o
);
  logic [N_IRQ-1:0] irq_q, irr_q, irr_d, isr_q, isr_d, imr_q, imr_d, cand_req;
  logic [2:0] ctrl_q, ctrl_d;
  logic [VEC_W-1:0] vbase_q, vbase_d, vector_q, vector_d;
  logic [ID_W-1:0] last_id_q, last_id_d, cur_id_q, cur_id_d;
  logic [ID_W-1:0] cand_id, isr_top, eoi_id, ack_id, wr_idx;
  logic spur_q, spur_d, intr_q, intr_d, vvalid_q, vvalid_d;
  logic cand_found, isr_any, eoi_any, ack_any, rot, cmd_wr, idx_ok, ack1, ack2;
  state_t state_q, state_d;
  int base;
  assign rot = ctrl_q[CTRL_ROT];
  assign cand_req = irr_q & ~imr_q;
  assign base = prio_base(rot, int'(last_id_q), N_IRQ);
  assign cmd_wr = wr_en && wr_addr == ADDR_CMD;
  assign wr_idx = wr_data[ID_W-1:0];
  assign idx_ok = int'(wr_idx) < N_IRQ;
  assign ack1 = state_q == IDLE && inta;
  assign ack2 = state_q == ACK1 && inta;
  pic_prio_resolver #(.N_IRQ(N_IRQ), .ID_W(ID_W)) u_cand (
    .req(cand_req), .isr(isr_q), .rot(rot), .last_id(last_id_q),
    .found(cand_found), .id(cand_id), .isr_any(isr_any), .isr_top_id(isr_top)
  );
  pic_prio_resolver #(.N_IRQ(N_IRQ), .ID_W(ID_W)) u_isr (
    .req(isr_q), .isr(cand_req), .rot(rot), .last_id(last_id_q),
    .found(eoi_any), .id(eoi_id), .isr_any(ack_any), .isr_top_id(ack_id)
  );
  always_comb begin
    irr_d = ctrl_q[CTRL_LTIM] ? irq
          : (irr_q & ~((ack1 && ack_any) ? N_IRQ'(1) << ack_id : '0)) | (irq & ~irq_q);
    isr_d = isr_q;
    last_id_d = last_id_q;
    if (cmd_wr && wr_data[7:6] == CMD_NSEOI && eoi_any) begin
      isr_d[eoi_id] = 1'b0;
      last_id_d = rot ? eoi_id : last_id_q;
    end
    if (cmd_wr && wr_data[7:6] == CMD_SEOI && idx_ok) isr_d[wr_idx] = 1'b0;
    if (cmd_wr && wr_data[7:6] == CMD_SETPRI && idx_ok) last_id_d = wr_idx;
    if (ack1 && ack_any) isr_d[ack_id] = 1'b1;
    if (ack2 && ctrl_q[CTRL_AEOI] && !spur_q) begin
      isr_d[cur_id_q] = 1'b0;
      last_id_d = rot ? cur_id_q : last_id_d;
    end
    state_d = ack1 ? ACK1 : ack2 ? IDLE : state_q;
    cur_id_d = ack1 ? (ack_any ? ack_id : ID_W'(N_IRQ - 1)) : cur_id_q;
    spur_d = ack1 ? !ack_any : spur_q;
    vector_d = ack2 ? vbase_q + VEC_W'(cur_id_q) : vector_q;
    vvalid_d = ack2;
    intr_d = cand_found && state_d == IDLE
          && (!isr_any || prio_rank(int'(cand_id), base, N_IRQ) < prio_rank(int'(isr_top), base, N_IRQ));
    ctrl_d = (wr_en && wr_addr == ADDR_CTRL) ? wr_data[2:0] : ctrl_q;
    vbase_d = (wr_en && wr_addr == ADDR_VBASE) ? wr_data : vbase_q;
    imr_d = (wr_en && wr_addr == ADDR_IMR) ? N_IRQ'(wr_data) : imr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= '0;
      irr_q <= '0;
      isr_q <= '0;
      imr_q <= '0;
      ctrl_q <= '0;
      vbase_q <= '0;
      last_id_q <= ID_W'(N_IRQ - 1);
      cur_id_q <= '0;
      spur_q <= 1'b0;
      state_q <= IDLE;
      intr_q <= 1'b0;
      vector_q <= '0;
      vvalid_q <= 1'b0;
    end else begin
      irq_q <= irq;
      irr_q <= irr_d;
      isr_q <= isr_d;
      imr_q <= imr_d;
      ctrl_q <= ctrl_d;
      vbase_q <= vbase_d;
      last_id_q <= last_id_d;
      cur_id_q <= cur_id_d;
      spur_q <= spur_d;
      state_q <= state_d;
      intr_q <= intr_d;
      vector_q <= vector_d;
      vvalid_q <= vvalid_d;
    end
  end
  assign intr = intr_q;
  assign vector = vector_q;
  assign vector_valid = vvalid_q;
  assign irr_o = irr_q;
  assign isr_o = isr_q;
endmodule
